axil_register_file: RTL and testbench
=====================================

AXIL_REGISTER_FILE -- requirements
Module: axil_register_file

Interface
REQ-001 Parameter: NUM_REGS, default 16, number of 32-bit registers (range 1..256).
REQ-002 Parameter: BASE_ADDR, default 32'h0000_0000, byte address of register 0, 4-byte aligned.
REQ-003 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: axil  AXIL_IF.Slave  32-bit AXI4-Lite  bus from the master.
REQ-006 Port: reg_q  output  NUM_REGS x 32  current register contents.
REQ-007 Port: reg_wr  output  NUM_REGS  one-cycle pulse per register, high the cycle after that register is written.

Function
REQ-008 Register index SHALL be (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
REQ-009 In range SHALL mean BASE_ADDR <= addr < BASE_ADDR + 4*NUM_REGS; otherwise out of range.
REQ-010 Write FSM states SHALL be W_IDLE, W_ADDR (address held), W_DATA (data held) and W_RESP.
REQ-011 awready SHALL be high in W_IDLE and W_DATA; wready SHALL be high in W_IDLE and W_ADDR; both low in W_RESP.
REQ-012 AW and W handshakes SHALL be accepted in either order or in the same cycle; a lone AW goes to W_ADDR, a lone W goes to W_DATA.
REQ-013 When both address and data are held, the write SHALL commit on that clock edge, the FSM SHALL enter W_RESP, and bvalid SHALL be high the next cycle.
REQ-014 bresp SHALL be OKAY for in-range addresses; for out-of-range addresses bresp SHALL be DECERR and no register or reg_wr SHALL change.
REQ-015 bvalid and bresp SHALL hold until bready is high; W_RESP SHALL then return to W_IDLE, so at most one write is outstanding.
REQ-016 Read FSM states SHALL be R_IDLE (arready high) and R_RESP (arready low).
REQ-017 On an AR handshake, rdata and rresp SHALL be registered and rvalid SHALL be high the next cycle (latency 1).
REQ-018 rdata, rresp and rvalid SHALL hold until rready is high; the FSM SHALL then return to R_IDLE.
REQ-019 An out-of-range read SHALL return rdata 0 with rresp DECERR.
REQ-020 A read and a commit to the same register on the same edge SHALL return the pre-write value.
REQ-021 The read and write paths SHALL be independent; neither stalls the other.
REQ-022 awprot and arprot SHALL be ignored.

Reset
REQ-023 While rst is high: all registers 0, reg_wr 0, bvalid 0, rvalid 0, bresp OKAY, rresp OKAY, rdata 0, and both FSMs in their idle states.
REQ-024 awready, wready and arready SHALL be 0 while rst is high and 1 on the first cycle after rst falls.
REQ-025 Reset mid-transaction SHALL drop any held address or data and any pending response without committing it.

Configuration
REQ-026 Macro AXIL_REGFILE_WSTRB_EN defined: on commit, byte lane n SHALL be written only when wstrb[n] is 1, and reg_wr SHALL still pulse even when wstrb is 0.
REQ-027 Macro AXIL_REGFILE_WSTRB_EN undefined: wstrb SHALL be ignored and all 4 bytes SHALL be written.

Structure
REQ-028 Package axil_pkg SHALL hold the axi_resp_t enum (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), the axi_prot_t enum, and the constants AXIL_DATA_W=32 and AXIL_ADDR_W=32.
REQ-029 The block SHALL be a single module with no sub-module; the FSM state enums SHALL stay local to the module.

Verification
REQ-030 AW 0x04 and W 0xDEADBEEF, wstrb 0xF, in the same cycle -> bvalid one cycle later with OKAY; reg_q[1]=0xDEADBEEF; reg_wr[1] pulses once.
REQ-031 W 0x12345678 first, AW 0x08 three cycles later, bready held low for 5 cycles -> bvalid and bresp stable for the whole stall; reg_q[2]=0x12345678.
REQ-032 AR 0x40 with NUM_REGS=16 -> rvalid one cycle later, rdata 0, rresp DECERR; AW 0x40 -> bresp DECERR and no reg_q change.
REQ-033 reg_q[3]=0xAAAA5555, then AR 0x0C and a write commit of 0x1 to 0x0C on the same edge -> rdata 0xAAAA5555; reg_q[3]=0x1 afterwards.
REQ-034 With AXIL_REGFILE_WSTRB_EN defined, reg_q[0]=0xFFFFFFFF, then write 0x00000000 with wstrb 0x5 -> reg_q[0]=0xFF00FF00.
REQ-035 rst asserted one cycle after an AW-only handshake -> all outputs at reset values; a new full write after reset succeeds with OKAY.

Source files
------------

// File: rtl/axil_register_file_pkg.sv
// Shared AXI4-Lite types and widths for the register file slice.
package axil_pkg;

    localparam int unsigned AXIL_DATA_W = 32;
    localparam int unsigned AXIL_ADDR_W = 32;
    localparam int unsigned AXIL_STRB_W = AXIL_DATA_W / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_t;

    // Common AxPROT encodings; this block never interprets them.
    typedef enum logic [2:0] {
        PROT_SECURE_DATA = 3'b000,
        PROT_PRIVILEGED  = 3'b001,
        PROT_NONSECURE   = 3'b010,
        PROT_INSTRUCTION = 3'b100
    } axi_prot_t;

endpackage

// File: rtl/axil_register_file_if.sv
// AXI4-Lite bus bundle (32-bit address and data) with master/slave views.
interface AXIL_IF;
    import axil_pkg::*;

    logic [AXIL_ADDR_W-1:0] awaddr;
    axi_prot_t              awprot;
    logic                   awvalid;
    logic                   awready;

    logic [AXIL_DATA_W-1:0] wdata;
    logic [AXIL_STRB_W-1:0] wstrb;
    logic                   wvalid;
    logic                   wready;

    axi_resp_t              bresp;
    logic                   bvalid;
    logic                   bready;

    logic [AXIL_ADDR_W-1:0] araddr;
    axi_prot_t              arprot;
    logic                   arvalid;
    logic                   arready;

    logic [AXIL_DATA_W-1:0] rdata;
    axi_resp_t              rresp;
    logic                   rvalid;
    logic                   rready;

    modport Master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport Slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/axil_register_file.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers at BASE_ADDR.
// Independent write (AW/W in any order) and read FSMs, one transaction
// outstanding per direction. Out-of-range accesses answer DECERR.
// Optional: define AXIL_REGFILE_WSTRB_EN to honour wstrb byte lanes;
// otherwise every commit writes all four bytes.
module axil_register_file
    import axil_pkg::*;
#(
    parameter int unsigned            NUM_REGS  = 16,
    parameter logic [AXIL_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    AXIL_IF.Slave                                axil,
    output logic [NUM_REGS-1:0][AXIL_DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]                  reg_wr
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rstate_t;

    wstate_t wstate;
    rstate_t rstate;

    // Address decode for both channels
    logic [AXIL_ADDR_W-1:0] aw_off;
    logic [AXIL_ADDR_W-1:0] ar_off;
    logic                   aw_hit;
    logic                   ar_hit;
    logic [IDX_W-1:0]       aw_idx;
    logic [IDX_W-1:0]       ar_idx;

    assign aw_off = axil.awaddr - BASE_ADDR;
    assign ar_off = axil.araddr - BASE_ADDR;
    assign aw_hit = (axil.awaddr >= BASE_ADDR) &&
                    ({2'b00, aw_off[AXIL_ADDR_W-1:2]} < AXIL_ADDR_W'(NUM_REGS));
    assign ar_hit = (axil.araddr >= BASE_ADDR) &&
                    ({2'b00, ar_off[AXIL_ADDR_W-1:2]} < AXIL_ADDR_W'(NUM_REGS));
    assign aw_idx = aw_off[IDX_W+1:2];
    assign ar_idx = ar_off[IDX_W+1:2];

    // Held half of a split write
    logic                   hold_hit;
    logic [IDX_W-1:0]       hold_idx;
    logic [AXIL_DATA_W-1:0] hold_data;
`ifdef AXIL_REGFILE_WSTRB_EN
    logic [AXIL_STRB_W-1:0] hold_strb;
    logic [AXIL_STRB_W-1:0] commit_strb;
`endif

    logic                   aw_fire;
    logic                   w_fire;
    logic                   ar_fire;
    logic                   commit;
    logic                   commit_hit;
    logic [IDX_W-1:0]       commit_idx;
    logic [AXIL_DATA_W-1:0] commit_data;

    // Commit fires on the edge where the second half of the write arrives;
    // address/data come from the hold registers or straight off the bus.
    always_comb begin
        aw_fire     = axil.awvalid && axil.awready;
        w_fire      = axil.wvalid && axil.wready;
        ar_fire     = axil.arvalid && axil.arready;
        commit      = 1'b0;
        unique case (wstate)
            W_IDLE:  commit = aw_fire && w_fire;
            W_ADDR:  commit = w_fire;
            W_DATA:  commit = aw_fire;
            default: commit = 1'b0;
        endcase
        commit_hit  = (wstate == W_ADDR) ? hold_hit : aw_hit;
        commit_idx  = (wstate == W_ADDR) ? hold_idx : aw_idx;
        commit_data = (wstate == W_DATA) ? hold_data : axil.wdata;
`ifdef AXIL_REGFILE_WSTRB_EN
        commit_strb = (wstate == W_DATA) ? hold_strb : axil.wstrb;
`endif
    end

    // Write FSM: handshake readies and the B response are registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate       <= W_IDLE;
            axil.awready <= 1'b0;
            axil.wready  <= 1'b0;
            axil.bvalid  <= 1'b0;
            axil.bresp   <= OKAY;
            hold_hit     <= 1'b0;
            hold_idx     <= '0;
            hold_data    <= '0;
`ifdef AXIL_REGFILE_WSTRB_EN
            hold_strb    <= '0;
`endif
        end else begin
            unique case (wstate)
                W_IDLE: begin
                    axil.awready <= 1'b1;
                    axil.wready  <= 1'b1;
                    if (aw_fire && w_fire) begin
                        axil.awready <= 1'b0;
                        axil.wready  <= 1'b0;
                        axil.bvalid  <= 1'b1;
                        axil.bresp   <= commit_hit ? OKAY : DECERR;
                        wstate       <= W_RESP;
                    end else if (aw_fire) begin
                        hold_hit     <= aw_hit;
                        hold_idx     <= aw_idx;
                        axil.awready <= 1'b0;
                        wstate       <= W_ADDR;
                    end else if (w_fire) begin
                        hold_data    <= axil.wdata;
`ifdef AXIL_REGFILE_WSTRB_EN
                        hold_strb    <= axil.wstrb;
`endif
                        axil.wready  <= 1'b0;
                        wstate       <= W_DATA;
                    end
                end
                W_ADDR, W_DATA: begin
                    if (commit) begin
                        axil.awready <= 1'b0;
                        axil.wready  <= 1'b0;
                        axil.bvalid  <= 1'b1;
                        axil.bresp   <= commit_hit ? OKAY : DECERR;
                        wstate       <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (axil.bready) begin
                        axil.bvalid  <= 1'b0;
                        axil.awready <= 1'b1;
                        axil.wready  <= 1'b1;
                        wstate       <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Register storage and one-cycle write strobes; out-of-range commits are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_q  <= '0;
            reg_wr <= '0;
        end else begin
            reg_wr <= '0;
            if (commit && commit_hit) begin
                reg_wr[commit_idx] <= 1'b1;
`ifdef AXIL_REGFILE_WSTRB_EN
                for (int unsigned b = 0; b < AXIL_STRB_W; b++) begin
                    if (commit_strb[b]) begin
                        reg_q[commit_idx][b*8 +: 8] <= commit_data[b*8 +: 8];
                    end
                end
`else
                reg_q[commit_idx] <= commit_data;
`endif
            end
        end
    end

    // Read FSM: samples reg_q before any same-edge commit lands
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate       <= R_IDLE;
            axil.arready <= 1'b0;
            axil.rvalid  <= 1'b0;
            axil.rresp   <= OKAY;
            axil.rdata   <= '0;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    axil.arready <= 1'b1;
                    if (ar_fire) begin
                        axil.arready <= 1'b0;
                        axil.rvalid  <= 1'b1;
                        axil.rdata   <= ar_hit ? reg_q[ar_idx] : '0;
                        axil.rresp   <= ar_hit ? OKAY : DECERR;
                        rstate       <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (axil.rready) begin
                        axil.rvalid  <= 1'b0;
                        axil.arready <= 1'b1;
                        rstate       <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    // Protection bits, byte offset within a word and (when disabled) strobes are don't-care
    logic unused_bits;
`ifdef AXIL_REGFILE_WSTRB_EN
    assign unused_bits = ^{axil.awprot, axil.arprot, aw_off[1:0], ar_off[1:0]};
`else
    assign unused_bits = ^{axil.awprot, axil.arprot, aw_off[1:0], ar_off[1:0], axil.wstrb};
`endif

endmodule

// File: tb/tb_axil_register_file.sv
// Self-checking bench for axil_register_file (NUM_REGS=16, BASE_ADDR=0).
// Expected B and R responses go into queues when a transaction is driven
// and are popped when the DUT presents them; a register model tracks reg_q.
module tb_axil_register_file;
    import axil_pkg::*;

    localparam int unsigned NREGS = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREGS-1:0][31:0] reg_q;
    logic [NREGS-1:0]       reg_wr;

    AXIL_IF axil();

    axil_register_file #(
        .NUM_REGS (NREGS),
        .BASE_ADDR(BASE)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .axil  (axil),
        .reg_q (reg_q),
        .reg_wr(reg_wr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [NREGS];
    logic [1:0]  b_exp_q [$];
    logic [33:0] r_exp_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_rng(input logic [31:0] addr);
        return (addr >= BASE) && (addr < BASE + 32'(4 * NREGS));
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREGS; i++)
            check_val($sformatf("%s reg_q[%0d]", tag, i), reg_q[i], model[i]);
    endtask

    task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int bstall);
        bit               aw_done;
        bit               w_done;
        bit               aw_fire;
        bit               w_fire;
        bit               hit;
        int               idx;
        int               cyc;
        logic [NREGS-1:0] wr_exp;
        logic [1:0]       resp_exp;
        logic [1:0]       resp_pop;
        aw_done  = 1'b0;
        w_done   = 1'b0;
        cyc      = 0;
        hit      = in_rng(addr);
        idx      = int'((addr - BASE) >> 2);
        resp_exp = hit ? 2'd0 : 2'd3;
        b_exp_q.push_back(resp_exp);
        axil.awaddr = addr;
        axil.wdata  = data;
        axil.wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            axil.awvalid = !aw_done && (cyc >= aw_dly);
            axil.wvalid  = !w_done && (cyc >= w_dly);
            aw_fire = axil.awvalid && axil.awready;
            w_fire  = axil.wvalid && axil.wready;
            tick();
            cyc++;
            aw_done = aw_done || aw_fire;
            w_done  = w_done || w_fire;
            if (!(aw_done && w_done)) begin
                check_val("b_early", 32'(axil.bvalid), 32'd0);
                if (aw_done)
                    check_val("w_addr_ready", 32'({axil.awready, axil.wready}), 32'd1);
                else if (w_done)
                    check_val("w_data_ready", 32'({axil.awready, axil.wready}), 32'd2);
            end
        end
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        check_val("w_hs_done", 32'({aw_done, w_done}), 32'd3);

        wr_exp = '0;
        if (hit) begin
`ifdef AXIL_REGFILE_WSTRB_EN
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
`else
            model[idx] = data;
`endif
            wr_exp[idx] = 1'b1;
        end

        check_val("b_latency", 32'(axil.bvalid), 32'd1);
        check_val("reg_wr_pulse", 32'(reg_wr), 32'(wr_exp));
        check_val("w_resp_ready", 32'({axil.awready, axil.wready}), 32'd0);
        for (int i = 0; i < bstall; i++) begin
            axil.bready = 1'b0;
            tick();
            check_val("b_hold_valid", 32'(axil.bvalid), 32'd1);
            check_val("b_hold_resp", 32'(axil.bresp), 32'(resp_exp));
            check_val("reg_wr_once", 32'(reg_wr), 32'd0);
        end
        axil.bready = 1'b1;
        resp_pop = b_exp_q.pop_front();
        check_val("bresp", 32'(axil.bresp), 32'(resp_pop));
        tick();
        axil.bready = 1'b0;
        check_val("b_release", 32'(axil.bvalid), 32'd0);
        check_val("reg_wr_clear", 32'(reg_wr), 32'd0);
    endtask

    task automatic read_txn(input logic [31:0] addr, input int rstall);
        bit          hit;
        bit          done;
        bit          fire;
        int          idx;
        int          cyc;
        logic [33:0] exp;
        logic [33:0] pop;
        hit = in_rng(addr);
        idx = int'((addr - BASE) >> 2);
        if (hit) exp = {2'd0, model[idx]};
        else     exp = {2'd3, 32'h0};
        r_exp_q.push_back(exp);
        axil.araddr  = addr;
        axil.arvalid = 1'b1;
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 40) begin
            fire = axil.arready;
            tick();
            cyc++;
            done = fire;
        end
        axil.arvalid = 1'b0;
        check_val("ar_hs_done", 32'(done), 32'd1);
        check_val("r_latency", 32'(axil.rvalid), 32'd1);
        for (int i = 0; i < rstall; i++) begin
            axil.rready = 1'b0;
            tick();
            check_val("r_hold_valid", 32'(axil.rvalid), 32'd1);
            check_val("r_hold_data", axil.rdata, exp[31:0]);
            check_val("r_busy_arready", 32'(axil.arready), 32'd0);
        end
        axil.rready = 1'b1;
        pop = r_exp_q.pop_front();
        check_val("rdata", axil.rdata, pop[31:0]);
        check_val("rresp", 32'(axil.rresp), 32'(pop[33:32]));
        tick();
        axil.rready = 1'b0;
        check_val("r_release", 32'(axil.rvalid), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, " readies"}, 32'({axil.awready, axil.wready, axil.arready}), 32'd0);
        check_val({tag, " bvalid"}, 32'(axil.bvalid), 32'd0);
        check_val({tag, " rvalid"}, 32'(axil.rvalid), 32'd0);
        check_val({tag, " bresp"}, 32'(axil.bresp), 32'd0);
        check_val({tag, " rresp"}, 32'(axil.rresp), 32'd0);
        check_val({tag, " rdata"}, axil.rdata, 32'd0);
        check_val({tag, " reg_wr"}, 32'(reg_wr), 32'd0);
        check_regs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        rst          = 1'b1;
        axil.awaddr  = '0;
        axil.awprot  = PROT_SECURE_DATA;
        axil.awvalid = 1'b0;
        axil.wdata   = '0;
        axil.wstrb   = '0;
        axil.wvalid  = 1'b0;
        axil.bready  = 1'b0;
        axil.araddr  = '0;
        axil.arprot  = PROT_PRIVILEGED;
        axil.arvalid = 1'b0;
        axil.rready  = 1'b0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;

        repeat (3) tick();
        check_reset_state("reset");
        rst = 1'b0;
        tick();
        check_val("ready_after_rst", 32'({axil.awready, axil.wready, axil.arready}), 32'd7);

        // AW and W together
        write_txn(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        check_val("same_cycle reg1", reg_q[1], 32'hDEADBEEF);

        // W first, AW three cycles later, B stalled
        write_txn(32'h08, 32'h12345678, 4'hF, 3, 0, 5);
        check_val("w_first reg2", reg_q[2], 32'h12345678);

        // AW first, W later
        write_txn(32'h1C, 32'h0BADF00D, 4'hF, 0, 2, 1);

        // Out-of-range read and write
        read_txn(32'h40, 0);
        write_txn(32'h40, 32'h5A5A5A5A, 4'hF, 0, 0, 0);
        write_txn(32'hFFFF_FFFC, 32'h11111111, 4'hF, 1, 0, 0);
        check_regs("decerr");

        // Read and commit to the same register on the same edge
        write_txn(32'h0C, 32'hAAAA5555, 4'hF, 0, 0, 0);
        fork
            read_txn(32'h0C, 1);
            write_txn(32'h0C, 32'h00000001, 4'hF, 0, 0, 0);
        join
        check_val("rw_same_edge reg3", reg_q[3], 32'h00000001);

`ifdef AXIL_REGFILE_WSTRB_EN
        write_txn(32'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        write_txn(32'h00, 32'h00000000, 4'h5, 0, 0, 0);
        check_val("strb_merge reg0", reg_q[0], 32'hFF00FF00);
        write_txn(32'h10, 32'h00001234, 4'h0, 0, 0, 0);
        check_val("strb_none reg4", reg_q[4], 32'h00000000);
`else
        write_txn(32'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        write_txn(32'h00, 32'h00001111, 4'h0, 0, 0, 0);
        check_val("strb_ignored reg0", reg_q[0], 32'h00001111);
`endif

        // Random writes to every register, byte offset bits scrambled
        for (int i = 0; i < NREGS; i++) begin
            a = 32'(i * 4) | 32'($urandom_range(3));
            write_txn(a, $urandom, 4'hF, int'($urandom_range(3)), int'($urandom_range(3)),
                      int'($urandom_range(2)));
        end
        check_regs("random");

        // Read back, with a concurrent write on another register every other time
        for (int i = 0; i < NREGS; i++) begin
            a = 32'(i * 4) | 32'($urandom_range(3));
            if (i % 2 == 1) begin
                fork
                    read_txn(a, int'($urandom_range(2)));
                    write_txn(32'((i - 1) * 4), $urandom, 4'hF, 0, 1, int'($urandom_range(3)));
                join
            end else begin
                read_txn(a, int'($urandom_range(2)));
            end
        end
        check_regs("readback");

        // Reset one cycle after an AW-only handshake
        axil.awaddr  = 32'h14;
        axil.awvalid = 1'b1;
        tick();
        axil.awvalid = 1'b0;
        check_val("aw_only bvalid", 32'(axil.bvalid), 32'd0);
        rst = 1'b1;
        tick();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        check_reset_state("mid_rst");
        rst = 1'b0;
        tick();
        check_val("ready_after_mid_rst", 32'({axil.awready, axil.wready, axil.arready}), 32'd7);
        write_txn(32'h18, 32'h00C0FFEE, 4'hF, 2, 0, 0);
        check_regs("post_rst");
        read_txn(32'h18, 0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
